mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbiter and sequencer for the single data-memory port shared by the instruction-fetch unit and the load/store queue. Each requester issues one-cycle request pulses, which are captured into a one-deep pending slot per requester. The arbiter grants the port round-robin and holds a level request/ack handshake toward memory. It returns a one-cycle completion pulse with read data to the owning requester, and aborts with an error if memory does not answer within a bounded number of cycles.

## Interface
- TIMEOUT, 64: BUSY cycles allowed without m_ack before abort; legal range 2..256.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-high.
- if_req  in  1  fetch request pulse (read only).
- if_addr  in  32  fetch address.
- if_busy  out  1  fetch slot occupied.
- if_ack  out  1  fetch completion pulse.
- if_rdata  out  32  fetch read data, valid with if_ack.
- ls_req  in  1  LSQ request pulse.
- ls_we  in  1  1 = store.
- ls_addr  in  32  LSQ address.
- ls_wdata  in  32  store data.
- ls_busy  out  1  LSQ slot occupied.
- ls_ack  out  1  LSQ completion pulse.
- ls_rdata  out  32  load data; 0 for stores.
- m_req  out  1  memory request, level.
- m_we  out  1  memory write enable.
- m_addr  out  32  memory address.
- m_wdata  out  32  memory write data.
- m_ack  in  1  memory completion pulse.
- m_rdata  in  32  memory read data, valid with m_ack.
- err  out  1  pulses with if_ack/ls_ack when the transaction timed out.
- ovf  out  1  sticky: a request pulse arrived while its slot was occupied.

## Operation
- Slots: on a clk edge with Xreq=1 and slot X empty, latch we/addr/wdata and set X valid. Fetch we is forced 0. X_busy = slot valid (registered).
- Xreq=1 while slot X is valid: the request is dropped, the slot is unchanged, and ovf is set until reset.
- FSM states: IDLE, BUSY.
- IDLE, no valid slot: stay in IDLE.
- IDLE, one valid slot: grant it.
- IDLE, both slots valid: grant the requester not served last. last_grant resets to IF, so the first contested grant goes to LS.
- On grant (edge): m_req<=1, m_we/m_addr/m_wdata<=slot contents, record owner, last_grant<=owner, cnt<=0, state<=BUSY.
- BUSY, m_ack=1: m_req<=0, owner ack<=1, owner rdata<=(we ? 0 : m_rdata), err<=0, clear owner slot, state<=IDLE.
- BUSY, no ack, cnt==TIMEOUT-1: m_req<=0, owner ack<=1, owner rdata<=0, err<=1, clear owner slot, state<=IDLE.
- BUSY, no ack, otherwise: cnt<=cnt+1.
- m_ack in IDLE is ignored.
- m_addr/m_wdata/m_we hold their values after m_req falls; they are stable for the whole BUSY period.
- The non-owner slot keeps accepting and holding requests while the port is busy.
- cnt width is clog2(TIMEOUT); it never wraps, because the abort fires at TIMEOUT-1.

## Timing
- Reset (asynchronous): all outputs 0, both slots empty, state IDLE, cnt 0, last_grant IF, ovf 0. Reset during BUSY drops m_req immediately and discards the transaction with no ack.
- Request pulse sampled at edge N: X_busy=1 after N. If the arbiter is IDLE, m_req=1 after edge N+1.
- m_ack sampled at edge M: m_req=0 and ack/rdata/err valid for exactly the cycle after M. Slot X is empty after M, so a new Xreq is accepted from edge M+1.
- IDLE lasts at least one cycle between transactions. Minimum back-to-back spacing is m_req high, one cycle low, then high again. Best-case request-to-ack latency is 3 edges (m_ack in the first BUSY cycle).
- Timeout: m_req stays high for exactly TIMEOUT cycles, then err/ack pulse.
- A request pulse on the same edge as its own slot's clear is rejected, because the slot is still valid at that edge; ovf is set.
- if_ack and ls_ack are never high in the same cycle.

## Test plan
- Single load: ls_req, ls_addr=0x100, we=0; m_ack after 2 BUSY cycles with m_rdata=0xDEADBEEF -> ls_ack pulse with ls_rdata=0xDEADBEEF, err=0, ls_busy clears, if_ack stays 0.
- Store: ls_we=1, addr=0x40, wdata=0x12345678 -> m_we=1, m_addr=0x40, m_wdata=0x12345678; m_ack -> ls_ack with ls_rdata=0.
- Contention: if_req and ls_req on the same edge after reset -> LS granted first, IF second. Repeat with both slots refilled -> IF granted first (alternation).
- Timeout with TIMEOUT=4, m_ack never asserted -> m_req high exactly 4 cycles, then ls_ack=1 with err=1 and ls_rdata=0. A late m_ack is ignored.
- Overflow: second ls_req while ls_busy=1 -> ovf=1 (sticky), the first request completes unchanged, and exactly one ls_ack occurs.
- Reset mid-BUSY: assert rst_n while m_req=1 -> m_req, busy and ack all drop at once with no ack; the next request after reset completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter for the shared data-memory port (fetch vs load/store)
module mem_port_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_busy,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_busy,
    output logic        ls_ack,
    output logic [31:0] ls_rdata,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_ack,
    input  logic [31:0] m_rdata,
    output logic        err,
    output logic        ovf
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_if_v;
    logic [31:0] r_if_addr;
    logic        r_ls_v;
    logic        r_ls_we;
    logic [31:0] r_ls_addr;
    logic [31:0] r_ls_wdata;

    logic        r_owner_ls;
    logic        r_last_ls;
    logic [CW-1:0] r_cnt;

    logic        r_m_req;
    logic        r_m_we;
    logic [31:0] r_m_addr;
    logic [31:0] r_m_wdata;
    logic        r_if_ack;
    logic [31:0] r_if_rdata;
    logic        r_ls_ack;
    logic [31:0] r_ls_rdata;
    logic        r_err;
    logic        r_ovf;

    logic        w_grant;
    logic        w_grant_ls;
    logic        w_done;
    logic        w_timeout;
    logic        w_clr_if;
    logic        w_clr_ls;

    // State register; reset abandons any in-flight transaction without an ack.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus grant/completion decode. A contested grant goes to the side not served last.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_grant_ls  = 1'b0;
        w_done      = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_if_v || r_ls_v) begin
                    w_grant     = 1'b1;
                    w_grant_ls  = r_ls_v && (!r_if_v || !r_last_ls);
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (m_ack) begin
                    w_done      = 1'b1;
                    w_state_nxt = IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_done      = 1'b1;
                    w_timeout   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_clr_if = w_done && !r_owner_ls;
    assign w_clr_ls = w_done && r_owner_ls;

    // One-deep request slots; a pulse into an occupied slot (even one clearing this edge) is dropped and flagged.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_if_v     <= 1'b0;
            r_if_addr  <= 32'd0;
            r_ls_v     <= 1'b0;
            r_ls_we    <= 1'b0;
            r_ls_addr  <= 32'd0;
            r_ls_wdata <= 32'd0;
            r_ovf      <= 1'b0;
        end else begin
            if (if_req && !r_if_v) begin
                r_if_v    <= 1'b1;
                r_if_addr <= if_addr;
            end else if (w_clr_if) begin
                r_if_v <= 1'b0;
            end
            if (ls_req && !r_ls_v) begin
                r_ls_v     <= 1'b1;
                r_ls_we    <= ls_we;
                r_ls_addr  <= ls_addr;
                r_ls_wdata <= ls_wdata;
            end else if (w_clr_ls) begin
                r_ls_v <= 1'b0;
            end
            if ((if_req && r_if_v) || (ls_req && r_ls_v)) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Memory-side handshake; address/data/we stay put after m_req drops until the next grant.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_m_req    <= 1'b0;
            r_m_we     <= 1'b0;
            r_m_addr   <= 32'd0;
            r_m_wdata  <= 32'd0;
            r_owner_ls <= 1'b0;
            r_last_ls  <= 1'b0;
            r_cnt      <= '0;
        end else begin
            if (w_grant) begin
                r_m_req    <= 1'b1;
                r_m_we     <= w_grant_ls ? r_ls_we : 1'b0;
                r_m_addr   <= w_grant_ls ? r_ls_addr : r_if_addr;
                r_m_wdata  <= w_grant_ls ? r_ls_wdata : 32'd0;
                r_owner_ls <= w_grant_ls;
                r_last_ls  <= w_grant_ls;
                r_cnt      <= '0;
            end else if (w_done) begin
                r_m_req <= 1'b0;
            end else if (r_state == BUSY) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Completion pulses: one cycle of ack/err/rdata to the owner; stores and aborts return zero data.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_if_ack   <= 1'b0;
            r_if_rdata <= 32'd0;
            r_ls_ack   <= 1'b0;
            r_ls_rdata <= 32'd0;
            r_err      <= 1'b0;
        end else begin
            r_if_ack   <= w_clr_if;
            r_ls_ack   <= w_clr_ls;
            r_err      <= w_timeout;
            r_if_rdata <= (w_clr_if && !w_timeout) ? m_rdata : 32'd0;
            r_ls_rdata <= (w_clr_ls && !w_timeout && !r_m_we) ? m_rdata : 32'd0;
        end
    end

    assign if_busy  = r_if_v;
    assign if_ack   = r_if_ack;
    assign if_rdata = r_if_rdata;
    assign ls_busy  = r_ls_v;
    assign ls_ack   = r_ls_ack;
    assign ls_rdata = r_ls_rdata;
    assign m_req    = r_m_req;
    assign m_we     = r_m_we;
    assign m_addr   = r_m_addr;
    assign m_wdata  = r_m_wdata;
    assign err      = r_err;
    assign ovf      = r_ovf;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic        if_busy, if_ack;
    logic [31:0] if_rdata;
    logic        ls_req = 1'b0, ls_we = 1'b0;
    logic [31:0] ls_addr = 32'd0, ls_wdata = 32'd0;
    logic        ls_busy, ls_ack;
    logic [31:0] ls_rdata;
    logic        m_req, m_we;
    logic [31:0] m_addr, m_wdata;
    logic        m_ack = 1'b0;
    logic [31:0] m_rdata = 32'd0;
    logic        err, ovf;

    int n_checks = 0;
    int n_err = 0;

    mem_port_arbiter #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_busy(if_busy), .if_ack(if_ack), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_busy(ls_busy), .ls_ack(ls_ack), .ls_rdata(ls_rdata),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_rdata(m_rdata), .err(err), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Reference model: slots as records, the port as "owner + cycles m_req has been high".
    int          md_owner;
    int          md_last;
    int          md_elapsed;
    int          md_done;
    int          md_g;
    bit          md_v[2];
    bit          md_oldv[2];
    bit          md_req[2];
    bit          md_we[2];
    logic [31:0] md_a[2];
    logic [31:0] md_d[2];
    bit          e_ack[2];
    logic [31:0] e_rd[2];
    logic        e_mreq, e_mwe, e_err, e_ovf;
    logic [31:0] e_maddr, e_mwd;

    always @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            md_owner = -1; md_last = 0; md_elapsed = 0;
            md_v = '{0, 0}; md_we = '{0, 0}; md_a = '{0, 0}; md_d = '{0, 0};
            e_ack = '{0, 0}; e_rd = '{0, 0};
            e_mreq = 0; e_mwe = 0; e_err = 0; e_ovf = 0; e_maddr = 0; e_mwd = 0;
        end else begin
            md_oldv = md_v;
            md_req[0] = if_req;
            md_req[1] = ls_req;
            e_ack = '{0, 0};
            e_rd = '{0, 0};
            e_err = 0;
            md_done = -1;
            if (md_owner >= 0) begin
                if (m_ack) begin
                    md_done = md_owner;
                    e_rd[md_owner] = md_we[md_owner] ? 32'd0 : m_rdata;
                end else if (md_elapsed == TMO) begin
                    md_done = md_owner;
                    e_err = 1;
                end else begin
                    md_elapsed++;
                end
                if (md_done >= 0) begin
                    e_ack[md_done] = 1;
                    e_mreq = 0;
                    md_owner = -1;
                end
            end else if (md_oldv[0] || md_oldv[1]) begin
                md_g = (md_oldv[0] && md_oldv[1]) ? 1 - md_last : (md_oldv[1] ? 1 : 0);
                md_owner = md_g;
                md_last = md_g;
                md_elapsed = 1;
                e_mreq = 1;
                e_mwe = md_we[md_g];
                e_maddr = md_a[md_g];
                e_mwd = md_d[md_g];
            end
            for (int x = 0; x < 2; x++) begin
                if (md_req[x] && md_oldv[x]) begin
                    e_ovf = 1;
                end else if (md_req[x]) begin
                    md_v[x] = 1;
                    md_we[x] = (x == 1) ? ls_we : 1'b0;
                    md_a[x] = (x == 1) ? ls_addr : if_addr;
                    md_d[x] = (x == 1) ? ls_wdata : 32'd0;
                end
                if (md_done == x) md_v[x] = 0;
            end
        end
    end

    typedef struct {
        logic        lsq;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        mack;
        logic [31:0] mrd;
        logic        e_mreq;
        logic        e_mwe;
        logic [31:0] e_maddr;
        logic [31:0] e_mwd;
        logic        e_busy;
        logic        e_ack;
        logic [31:0] e_rd;
        logic        e_err;
    } vec_t;

    vec_t vt[9];

    function automatic vec_t mk(input logic lsq, input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic mack, input logic [31:0] mrd,
                                input logic e_mreq_i, input logic e_mwe_i, input logic [31:0] e_maddr_i,
                                input logic [31:0] e_mwd_i, input logic e_busy_i, input logic e_ack_i,
                                input logic [31:0] e_rd_i, input logic e_err_i);
        vec_t v;
        v.lsq = lsq; v.we = we; v.addr = addr; v.wdata = wdata; v.mack = mack; v.mrd = mrd;
        v.e_mreq = e_mreq_i; v.e_mwe = e_mwe_i; v.e_maddr = e_maddr_i; v.e_mwd = e_mwd_i;
        v.e_busy = e_busy_i; v.e_ack = e_ack_i; v.e_rd = e_rd_i; v.e_err = e_err_i;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 20) $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        if_req = 0; ls_req = 0; m_ack = 0;
    endtask

    task automatic do_reset();
        clr();
        rst_n = 1;
        tick();
        tick();
        rst_n = 0;
    endtask

    int cnt;
    int seen;

    initial begin
        vt[0] = mk(1, 0, 32'h100, 32'h0,        0, 32'h0,        0, 0, 32'h0,   32'h0,        1, 0, 32'h0,        0);
        vt[1] = mk(0, 0, 32'h0,   32'h0,        0, 32'h0,        1, 0, 32'h100, 32'h0,        1, 0, 32'h0,        0);
        vt[2] = mk(0, 0, 32'h0,   32'h0,        0, 32'h0,        1, 0, 32'h100, 32'h0,        1, 0, 32'h0,        0);
        vt[3] = mk(0, 0, 32'h0,   32'h0,        1, 32'hDEADBEEF, 0, 0, 32'h100, 32'h0,        0, 1, 32'hDEADBEEF, 0);
        vt[4] = mk(0, 0, 32'h0,   32'h0,        0, 32'h0,        0, 0, 32'h100, 32'h0,        0, 0, 32'h0,        0);
        vt[5] = mk(1, 1, 32'h40,  32'h12345678, 0, 32'h0,        0, 0, 32'h100, 32'h0,        1, 0, 32'h0,        0);
        vt[6] = mk(0, 0, 32'h0,   32'h0,        0, 32'h0,        1, 1, 32'h40,  32'h12345678, 1, 0, 32'h0,        0);
        vt[7] = mk(0, 0, 32'h0,   32'h0,        1, 32'hFFFFFFFF, 0, 1, 32'h40,  32'h12345678, 0, 1, 32'h0,        0);
        vt[8] = mk(0, 0, 32'h0,   32'h0,        0, 32'h0,        0, 1, 32'h40,  32'h12345678, 0, 0, 32'h0,        0);

        do_reset();
        chk("reset_state", {if_busy, ls_busy, if_ack, ls_ack, err, ovf, m_req, m_we, m_addr},
            {8'h00, 32'h0});
        chk("reset_data", {m_wdata, ls_rdata}, 64'h0);

        for (int i = 0; i < 9; i++) begin
            ls_req = vt[i].lsq; ls_we = vt[i].we; ls_addr = vt[i].addr; ls_wdata = vt[i].wdata;
            m_ack = vt[i].mack; m_rdata = vt[i].mrd;
            tick();
            chk($sformatf("vec%0d_ctrl", i), {m_req, m_we, ls_busy, ls_ack, err, if_ack, m_addr},
                {vt[i].e_mreq, vt[i].e_mwe, vt[i].e_busy, vt[i].e_ack, vt[i].e_err, 1'b0, vt[i].e_maddr});
            chk($sformatf("vec%0d_data", i), {m_wdata, ls_rdata}, {vt[i].e_mwd, vt[i].e_rd});
        end
        clr(); ls_we = 0;

        do_reset();
        if_req = 1; if_addr = 32'h1000; ls_req = 1; ls_addr = 32'h2000; ls_wdata = 32'h0;
        tick(); clr();
        tick();
        chk("cont1_first", {m_req, m_addr}, {1'b1, 32'h2000});
        m_ack = 1; m_rdata = 32'hA;
        tick(); clr();
        chk("cont1_ls_ack", {ls_ack, if_ack, ls_rdata}, {1'b1, 1'b0, 32'hA});
        tick();
        chk("cont1_second", {m_req, m_addr}, {1'b1, 32'h1000});
        m_ack = 1; m_rdata = 32'hB;
        tick(); clr();
        chk("cont1_if_ack", {if_ack, ls_ack, if_rdata}, {1'b1, 1'b0, 32'hB});
        ls_req = 1; ls_addr = 32'h3000;
        tick(); clr();
        tick();
        m_ack = 1; m_rdata = 32'hC;
        tick(); clr();
        chk("solo_ls_ack", {ls_ack, ls_rdata}, {1'b1, 32'hC});
        if_req = 1; if_addr = 32'h1004; ls_req = 1; ls_addr = 32'h2004;
        tick(); clr();
        tick();
        chk("cont2_first", {m_req, m_addr}, {1'b1, 32'h1004});
        m_ack = 1;
        tick(); clr();
        tick();
        chk("cont2_second", {m_req, m_addr}, {1'b1, 32'h2004});
        m_ack = 1;
        tick(); clr();
        tick();

        m_rdata = 32'hFFFFFFFF;
        ls_req = 1; ls_addr = 32'h500;
        tick(); clr();
        cnt = 0; seen = 0;
        for (int k = 0; k < 20 && seen == 0; k++) begin
            tick();
            if (m_req) cnt++;
            if (ls_ack) begin
                seen = 1;
                chk("to_err_data", {err, if_ack, ls_rdata}, {1'b1, 1'b0, 32'h0});
            end
        end
        chk("to_seen", 64'(seen), 64'd1);
        chk("to_mreq_cycles", 64'(cnt), 64'(TMO));
        m_ack = 1;
        tick(); clr();
        chk("to_late_ack", {m_req, ls_ack, if_ack, err}, 4'h0);

        do_reset();
        ls_req = 1; ls_addr = 32'h600; ls_we = 0;
        tick();
        chk("ovf_clear", {ovf, ls_busy}, {1'b0, 1'b1});
        ls_req = 1; ls_addr = 32'h700;
        tick(); clr();
        chk("ovf_set", {ovf, m_req, m_addr}, {1'b1, 1'b1, 32'h600});
        m_ack = 1; m_rdata = 32'h55;
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            tick(); clr();
            if (ls_ack) begin
                cnt++;
                chk("ovf_rdata", ls_rdata, 32'h55);
            end
        end
        chk("ovf_one_ack", 64'(cnt), 64'd1);
        chk("ovf_sticky", {ovf, ls_busy}, {1'b1, 1'b0});

        ls_req = 1; ls_addr = 32'h800;
        tick(); clr();
        tick();
        chk("rst_busy_before", m_req, 1'b1);
        #2 rst_n = 1;
        #1;
        chk("rst_async", {m_req, ls_busy, ls_ack, ovf, err}, 5'h0);
        tick();
        chk("rst_held", {m_req, ls_ack, if_ack}, 3'h0);
        rst_n = 0;
        ls_req = 1; ls_addr = 32'h900;
        tick(); clr();
        tick();
        chk("rst_next_grant", {m_req, m_addr}, {1'b1, 32'h900});
        m_ack = 1; m_rdata = 32'h77;
        tick(); clr();
        chk("rst_next_ack", {ls_ack, err, ls_rdata}, {1'b1, 1'b0, 32'h77});

        do_reset();
        for (int c = 0; c < 2000; c++) begin
            if_req = ($urandom % 4) == 0;
            if_addr = $urandom;
            ls_req = ($urandom % 4) == 0;
            ls_we = $urandom % 2;
            ls_addr = $urandom;
            ls_wdata = $urandom;
            m_ack = ($urandom % 3) == 0;
            m_rdata = $urandom;
            tick();
            chk("rnd_ctrl", {if_busy, ls_busy, if_ack, ls_ack, err, ovf, m_req, m_we, m_addr},
                {md_v[0], md_v[1], e_ack[0], e_ack[1], e_err, e_ovf, e_mreq, e_mwe, e_maddr});
            chk("rnd_data", {if_rdata, ls_rdata}, {e_rd[0], e_rd[1]});
            chk("rnd_wdata", m_wdata, e_mwd);
            if (if_ack && ls_ack) chk("rnd_both_acks", 1'b1, 1'b0);
        end
        clr();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
